branch_predict_ctrl: RTL

Controller for the 2-bit branch predictor, sitting between IF (lookup) and EX (resolve). Owns a table of 2-bit saturating counters indexed by PC. Sequences table initialisation after reset, answers one IF lookup per cycle, applies one EX update per cycle with write-first bypass, and raises a flush with a redirect PC on every misprediction. Keeps branch and misprediction statistics for the performance counters.

---
 rtl/branch_predict_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit saturating-counter branch predictor controller.
// Initialises the counter table after reset, answers one IF lookup per cycle,
// applies one EX update per cycle with write-first bypass, and raises a
// one-cycle flush with the corrected fetch PC on every misprediction.
module branch_predict_ctrl #(
  parameter int          IDX_BITS   = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [1:0]  pred_state,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        ready,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_BITS;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              state;
  logic [IDX_BITS-1:0] ptr;
  logic [1:0]          ctr_mem [DEPTH];

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [1:0]          ex_cur;
  logic [1:0]          ex_next;
  logic [1:0]          lookup_state;
  logic                run;
  logic                update;
  logic                mispredict;
  logic [31:0]         fix_pc;

  // PC bits outside the index field carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0],
                            ex_pc[31:IDX_BITS+2]};

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] next_ctr(input logic [1:0] cur, input logic taken);
    if (taken) return (cur == 2'b11) ? cur : cur + 2'd1;
    else       return (cur == 2'b00) ? cur : cur - 2'd1;
  endfunction

  // Decode the current cycle: indices, update/mispredict qualifiers, bypass.
  always_comb begin
    // NOTE: every combinational output gets a value on every path so no latch is inferred.
    if_idx       = if_pc[IDX_BITS+1:2];
    ex_idx       = ex_pc[IDX_BITS+1:2];
    run          = (state == ST_RUN);
    update       = run & ex_valid & ex_branch;
    mispredict   = update & (ex_taken != ex_pred_taken);
    ex_cur       = ctr_mem[ex_idx];
    ex_next      = next_ctr(ex_cur, ex_taken);
    fix_pc       = ex_taken ? ex_target : ex_pc + 32'd4;
    lookup_state = ctr_mem[if_idx];
    // Write-first: a lookup colliding with this cycle's update sees the new value.
    if (update && (ex_idx == if_idx)) begin
      lookup_state = ex_next;
    end
  end

  // Init/run sequencer plus all registered outputs and statistics.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state       <= ST_INIT;
      ptr         <= '0;
      ready       <= 1'b0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_state  <= 2'b00;
      flush       <= 1'b0;
      redirect_pc <= 32'd0;
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      case (state)
        ST_INIT: begin
          ready      <= 1'b0;
          pred_valid <= 1'b0;
          flush      <= 1'b0;
          ptr        <= ptr + IDX_BITS'(1);
          if (ptr == IDX_BITS'(DEPTH - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
          // A response landing in a flush cycle is suppressed; the read still happens.
          pred_valid <= if_valid & ~mispredict;
          if (if_valid) begin
            pred_state <= lookup_state;
            pred_taken <= lookup_state[1];
          end
          flush <= mispredict;
          if (mispredict) begin
            redirect_pc <= fix_pc;
            if (mispred_cnt != 32'hFFFF_FFFF) mispred_cnt <= mispred_cnt + 32'd1;
          end
          if (update && (branch_cnt != 32'hFFFF_FFFF)) begin
            branch_cnt <= branch_cnt + 32'd1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Counter table writes: init sweep in INIT, resolved-branch update in RUN.
  always_ff @(posedge clk) begin
    // NOTE: the table has no reset; the INIT sweep rewrites every entry before first use.
    if (reset) begin
      if (state == ST_INIT) begin
        ctr_mem[ptr] <= INIT_STATE;
      end else if (update) begin
        ctr_mem[ex_idx] <= ex_next;
      end
    end
  end

endmodule
